// File: rtl/meas_scan_ctrl_if.sv
// Readout stream from the scan sequencer to the packing logic.
// Each word carries the mux index it was captured from.
interface meas_scan_ctrl_if #(
    parameter int C_IDWIDTH = 24,
    parameter int C_ISWIDTH = 10
);
    logic [C_IDWIDTH-1:0] O_data;
    logic [C_ISWIDTH-1:0] O_idx;
    logic                 O_valid;
    logic                 I_ready;

    modport master (
        output O_data,
        output O_idx,
        output O_valid,
        input  I_ready
    );

    modport slave (
        input  O_data,
        input  O_idx,
        input  O_valid,
        output I_ready
    );
endinterface

// File: rtl/meas_scan_ctrl.sv
// Steps the measurement mux select over [first, last], waits a settle
// time at each index and streams out the captured word with its index.
module meas_scan_ctrl #(
    parameter int C_INUM    = 48,
    parameter int C_IDWIDTH = 24,
    parameter int C_ISWIDTH = 10,
    parameter int C_SETTLE  = 2
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_start,
    input  logic [C_ISWIDTH-1:0] I_first,
    input  logic [C_ISWIDTH-1:0] I_last,
    input  logic                 I_abort,
    output logic [C_ISWIDTH-1:0] O_sel,
    input  logic [C_IDWIDTH-1:0] I_mux_data,
    output logic                 O_busy,
    output logic                 O_done,
    output logic                 O_err,
    meas_scan_ctrl_if.master     rd
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [7:0]           SETTLE_END = 8'(C_SETTLE - 1);
    localparam logic [C_ISWIDTH-1:0] IDX_LIMIT  = C_ISWIDTH'(C_INUM);
    localparam logic [C_ISWIDTH-1:0] IDX_ONE    = C_ISWIDTH'(1);

    state_t               state, state_d;
    logic [C_ISWIDTH-1:0] sel, sel_d;
    logic [C_ISWIDTH-1:0] last, last_d;
    logic [7:0]           cnt, cnt_d;
    logic [C_IDWIDTH-1:0] data, data_d;
    logic [C_ISWIDTH-1:0] idx, idx_d;
    logic                 valid, valid_d;
    logic                 busy, busy_d;
    logic                 done, done_d;
    logic                 err, err_d;
    logic                 range_ok;

    assign range_ok = (I_first <= I_last) && (I_last < IDX_LIMIT);

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= IDLE;
            sel   <= '0;
            last  <= '0;
            cnt   <= '0;
            data  <= '0;
            idx   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            sel   <= sel_d;
            last  <= last_d;
            cnt   <= cnt_d;
            data  <= data_d;
            idx   <= idx_d;
            valid <= valid_d;
            busy  <= busy_d;
            done  <= done_d;
            err   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        sel_d   = sel;
        last_d  = last;
        cnt_d   = cnt;
        data_d  = data;
        idx_d   = idx;
        valid_d = valid;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state)
            IDLE: begin
                // abort masks start so a stray start cannot slip in
                if (I_start && !I_abort) begin
                    if (range_ok) begin
                        sel_d   = I_first;
                        last_d  = I_last;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (I_abort) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (cnt == SETTLE_END) begin
                    data_d  = I_mux_data;
                    idx_d   = sel;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt + 8'd1;
                end
            end
            HOLD: begin
                // abort wins over a same-cycle handshake
                if (I_abort) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (valid && rd.I_ready) begin
                    valid_d = 1'b0;
                    if (sel == last) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        sel_d   = sel + IDX_ONE;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign O_sel      = sel;
    assign O_busy     = busy;
    assign O_done     = done;
    assign O_err      = err;
    assign rd.O_data  = data;
    assign rd.O_idx   = idx;
    assign rd.O_valid = valid;

endmodule

// File: tb/tb_meas_scan_ctrl.sv
// Directed bench for meas_scan_ctrl: full scan, backpressure, single
// and rejected ranges, abort, start while busy and mid-scan reset.
module tb_meas_scan_ctrl;

    localparam int NUM = 48;
    localparam int DW  = 24;
    localparam int SW  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] first = '0;
    logic [SW-1:0] last = '0;
    logic          abort = 1'b0;
    logic [SW-1:0] sel;
    logic [DW-1:0] mux_data;
    logic          busy;
    logic          done;
    logic          err;

    meas_scan_ctrl_if #(.C_IDWIDTH(DW), .C_ISWIDTH(SW)) rd ();

    meas_scan_ctrl #(
        .C_INUM   (NUM),
        .C_IDWIDTH(DW),
        .C_ISWIDTH(SW),
        .C_SETTLE (2)
    ) dut (
        .I_clk     (clk),
        .I_rst     (rst),
        .I_start   (start),
        .I_first   (first),
        .I_last    (last),
        .I_abort   (abort),
        .O_sel     (sel),
        .I_mux_data(mux_data),
        .O_busy    (busy),
        .O_done    (done),
        .O_err     (err),
        .rd        (rd)
    );

    always #5 clk = ~clk;

    assign mux_data = DW'(32'(sel) * 32'h010101);

    int errors = 0;
    int checks = 0;

    int q_idx[$];
    int q_dat[$];
    int q_cyc[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int err_cnt  = 0;
    int cyc      = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (rd.O_valid && rd.I_ready && !abort) begin
                q_idx.push_back(int'(rd.O_idx));
                q_dat.push_back(int'(rd.O_data));
                q_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (err) err_cnt++;
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        q_idx.delete();
        q_dat.delete();
        q_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic start_scan(input logic [SW-1:0] f, input logic [SW-1:0] l);
        first = f;
        last  = l;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            step();
            if (done) break;
        end
        chk(tag, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        step();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rd.O_valid) break;
            step();
        end
        chk(tag, 32'(rd.O_valid), 32'd1);
    endtask

    initial begin
        rd.I_ready = 1'b1;
        step();
        step();
        chk("rst_sel",   32'(sel), 32'd0);
        chk("rst_data",  32'(rd.O_data), 32'd0);
        chk("rst_idx",   32'(rd.O_idx), 32'd0);
        chk("rst_valid", 32'(rd.O_valid), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        rst = 1'b0;
        step();

        // full scan 0..47
        clr();
        start_scan(10'd0, 10'd47);
        chk("full_sel_n1",  32'(sel), 32'd0);
        chk("full_busy_n1", 32'(busy), 32'd1);
        step();
        chk("full_valid_n2", 32'(rd.O_valid), 32'd0);
        step();
        chk("full_valid_n3", 32'(rd.O_valid), 32'd1);
        chk("full_data_n3",  32'(rd.O_data), 32'd0);
        wait_done("full_done", 400);
        repeat (3) step();
        chk("full_count", 32'(q_idx.size()), 32'd48);
        for (int i = 0; i < q_idx.size(); i++) begin
            chk("full_idx", 32'(q_idx[i]), 32'(i));
            chk("full_data", 32'(q_dat[i]), 32'(i) * 32'h010101);
            if (i > 0) chk("full_gap", 32'(q_cyc[i] - q_cyc[i-1]), 32'd3);
        end
        chk("full_done_once", 32'(done_cnt), 32'd1);
        if (q_cyc.size() > 0)
            chk("full_done_lat", 32'(done_cyc - q_cyc[$]), 32'd1);

        // backpressure 5..7
        clr();
        rd.I_ready = 1'b0;
        start_scan(10'd5, 10'd7);
        wait_valid("bp_valid", 20);
        for (int i = 0; i < 10; i++) begin
            chk("bp_idx",  32'(rd.O_idx), 32'd5);
            chk("bp_data", 32'(rd.O_data), 32'h050505);
            chk("bp_sel",  32'(sel), 32'd5);
            step();
        end
        rd.I_ready = 1'b1;
        wait_done("bp_done", 40);
        chk("bp_count", 32'(q_idx.size()), 32'd3);
        for (int i = 0; i < q_idx.size(); i++)
            chk("bp_order", 32'(q_idx[i]), 32'(5 + i));

        // single index 47
        clr();
        start_scan(10'd47, 10'd47);
        wait_done("one_done", 20);
        chk("one_count", 32'(q_idx.size()), 32'd1);
        if (q_idx.size() > 0) begin
            chk("one_idx",  32'(q_idx[0]), 32'd47);
            chk("one_data", 32'(q_dat[0]), 32'h2f2f2f);
        end
        chk("one_done_once", 32'(done_cnt), 32'd1);

        // rejected ranges
        clr();
        start_scan(10'd10, 10'd9);
        chk("rev_err",  32'(err), 32'd1);
        chk("rev_busy", 32'(busy), 32'd0);
        step();
        chk("rev_err_pulse", 32'(err), 32'd0);
        start_scan(10'd0, 10'd48);
        chk("big_err",  32'(err), 32'd1);
        chk("big_busy", 32'(busy), 32'd0);
        repeat (5) step();
        chk("rej_valid",   32'(rd.O_valid), 32'd0);
        chk("rej_words",   32'(q_idx.size()), 32'd0);
        chk("rej_err_cnt", 32'(err_cnt), 32'd2);

        // abort in HOLD of idx 3 with ready high
        clr();
        start_scan(10'd0, 10'd5);
        for (int i = 0; i < 40; i++) begin
            if (rd.O_valid && rd.O_idx == 10'd3) break;
            step();
        end
        chk("ab_hold3", 32'(rd.O_idx), 32'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_valid", 32'(rd.O_valid), 32'd0);
        chk("ab_busy",  32'(busy), 32'd0);
        chk("ab_done",  32'(done), 32'd0);
        repeat (5) step();
        chk("ab_idle",  32'(busy), 32'd0);
        chk("ab_words", 32'(q_idx.size()), 32'd3);
        chk("ab_nodone", 32'(done_cnt), 32'd0);

        // start while busy is ignored
        clr();
        start_scan(10'd0, 10'd4);
        step();
        first = 10'd20;
        last  = 10'd22;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sb_sel_low", 32'(sel <= 10'd4), 32'd1);
        wait_done("sb_done", 40);
        chk("sb_count", 32'(q_idx.size()), 32'd5);
        for (int i = 0; i < q_idx.size(); i++)
            chk("sb_idx", 32'(q_idx[i]), 32'(i));
        clr();
        start_scan(10'd20, 10'd22);
        chk("sb2_sel", 32'(sel), 32'd20);
        wait_done("sb2_done", 40);
        chk("sb2_count", 32'(q_idx.size()), 32'd3);
        for (int i = 0; i < q_idx.size(); i++)
            chk("sb2_idx", 32'(q_idx[i]), 32'(20 + i));

        // reset during SETTLE of idx 2
        clr();
        start_scan(10'd0, 10'd5);
        for (int i = 0; i < 40; i++) begin
            if (sel == 10'd2 && busy && !rd.O_valid) break;
            step();
        end
        chk("mr_at2", 32'(sel), 32'd2);
        rst = 1'b1;
        step();
        chk("mr_sel",   32'(sel), 32'd0);
        chk("mr_data",  32'(rd.O_data), 32'd0);
        chk("mr_idx",   32'(rd.O_idx), 32'd0);
        chk("mr_valid", 32'(rd.O_valid), 32'd0);
        chk("mr_busy",  32'(busy), 32'd0);
        chk("mr_done",  32'(done), 32'd0);
        chk("mr_err",   32'(err), 32'd0);
        rst = 1'b0;
        step();
        clr();
        start_scan(10'd0, 10'd1);
        wait_done("mr2_done", 40);
        repeat (3) step();
        chk("mr2_count", 32'(q_idx.size()), 32'd2);
        chk("mr2_done_once", 32'(done_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
